// File: rtl/sramc_pkg.sv
// rtl/sramc_pkg.sv - state encoding, AHB constants and clog2 helper for the SRAM bank controller
// SRAMC_ERR_RESP_EN adds the two ERROR-response states.
package sramc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_DATA
`ifdef SRAMC_ERR_RESP_EN
    ,
    ERR1,
    ERR2
`endif
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sramc_lane_decode.sv
// rtl/sramc_lane_decode.sv - little-endian byte-lane mask and misalign/oversize flags from hsize and address lsbs
// Oversize requests are clipped to the full word and unaligned ones aligned down; the flags report both cases.
module sramc_lane_decode
  import sramc_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OFF        = clog2(NB)
) (
  input  logic [2:0]     size,
  input  logic [OFF-1:0] addr_lsb,
  output logic [NB-1:0]  lanes,
  output logic           misalign,
  output logic           oversize
);

  localparam int NBW = OFF + 1;

  logic [2:0]     size_c;
  logic [OFF:0]   nbytes;
  logic [OFF-1:0] align_mask;
  logic [OFF-1:0] base;

  always_comb begin
    oversize   = size > 3'(OFF);
    size_c     = oversize ? 3'(OFF) : size;
    nbytes     = NBW'(1) << size_c;
    align_mask = OFF'(nbytes - 1'b1);
    misalign   = |(addr_lsb & align_mask);
    base       = addr_lsb & ~align_mask;
    lanes      = '0;
    for (int i = 0; i < NB; i++)
      lanes[i] = (i >= int'(base)) && (i < int'(base) + int'(nbytes));
  end

endmodule

// File: rtl/sramc_ahb_bank_ctrl.sv
// rtl/sramc_ahb_bank_ctrl.sv - AHB-Lite slave sequencing NUM_BANKS single-port synchronous SRAM banks
// Writes complete with zero wait, reads with one; SRAMC_ERR_RESP_EN enables two-cycle ERROR responses.
module sramc_ahb_bank_ctrl
  import sramc_pkg::*;
#(
  parameter int  AHB_ADDR_WIDTH  = 32,
  parameter int  DATA_WIDTH      = 32,
  parameter int  NUM_BANKS       = 4,
  parameter int  BANK_ADDR_WIDTH = 12,
  localparam int NB              = DATA_WIDTH / 8
) (
  input  logic                            hclk,
  input  logic                            hreset,
  input  logic                            hsel,
  input  logic [AHB_ADDR_WIDTH-1:0]       haddr,
  input  logic [1:0]                      htrans,
  input  logic                            hwrite,
  input  logic [2:0]                      hsize,
  input  logic                            hready,
  input  logic [DATA_WIDTH-1:0]           hwdata,
  output logic [DATA_WIDTH-1:0]           hrdata,
  output logic                            hreadyout,
  output logic                            hresp,
  output logic [NUM_BANKS-1:0]            sram_cs_n,
  output logic                            sram_we_n,
  output logic [NB-1:0]                   sram_be_n,
  output logic [BANK_ADDR_WIDTH-1:0]      sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_rdata
);

  localparam int OFF    = clog2(NB);
  localparam int BANK_W = clog2(NUM_BANKS);
  localparam int BW     = (BANK_W > 0) ? BANK_W : 1;

  state_t                     state, state_next;
  logic [BANK_ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]              bank_d, bank_q;
  logic [NB-1:0]              lanes_d, lanes_q;
  logic                       misalign, oversize;
  logic                       take;
  logic [DATA_WIDTH-1:0]      lane_bits, bank_rdata;
  logic [DATA_WIDTH-1:0]      bank_words [NUM_BANKS];
  logic                       unused_bits;

  // Only states that present hreadyout=1 may start a transfer, so RD_ISSUE/ERR1 never recapture.
  assign take = hsel && hready && hreadyout &&
                (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  sramc_lane_decode #(.DATA_WIDTH(DATA_WIDTH)) u_lane_decode (
    .size     (hsize),
    .addr_lsb (haddr[OFF-1:0]),
    .lanes    (lanes_d),
    .misalign (misalign),
    .oversize (oversize)
  );

  if (BANK_W > 0) begin : g_bank
    assign bank_d = haddr[OFF+BANK_ADDR_WIDTH +: BW];
  end else begin : g_no_bank
    assign bank_d = '0;
  end

`ifdef SRAMC_ERR_RESP_EN
  localparam int HI = OFF + BANK_ADDR_WIDTH + BANK_W;
  logic out_of_range, bad;
  if (HI < AHB_ADDR_WIDTH) begin : g_range
    assign out_of_range = |haddr[AHB_ADDR_WIDTH-1:HI];
  end else begin : g_full_range
    assign out_of_range = 1'b0;
  end
  assign bad = misalign | oversize | out_of_range;
`endif

  assign unused_bits = ^{haddr, misalign, oversize};

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_rd
    assign bank_words[k] = sram_rdata[k*DATA_WIDTH +: DATA_WIDTH];
  end
  assign bank_rdata = bank_words[bank_q];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_bits[8*i +: 8] = {8{lanes_q[i]}};
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= IDLE;
      addr_q  <= '0;
      bank_q  <= '0;
      lanes_q <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        addr_q  <= haddr[OFF +: BANK_ADDR_WIDTH];
        bank_q  <= bank_d;
        lanes_q <= lanes_d;
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      RD_ISSUE: state_next = RD_DATA;
`ifdef SRAMC_ERR_RESP_EN
      ERR1:     state_next = ERR2;
`endif
      default: begin
        if (take) state_next = hwrite ? WR : RD_ISSUE;
`ifdef SRAMC_ERR_RESP_EN
        if (take && bad) state_next = ERR1;
`endif
      end
    endcase
  end

  always_comb begin
    sram_cs_n  = '1;
    sram_we_n  = 1'b1;
    sram_be_n  = '1;
    sram_wdata = '0;
    hrdata     = '0;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      WR: begin
        sram_cs_n  = ~(NUM_BANKS'(1) << bank_q);
        sram_we_n  = 1'b0;
        sram_be_n  = ~lanes_q;
        sram_wdata = hwdata;
      end
      RD_ISSUE: begin
        sram_cs_n = ~(NUM_BANKS'(1) << bank_q);
        sram_be_n = ~lanes_q;
        hreadyout = 1'b0;
      end
      RD_DATA: hrdata = bank_rdata & lane_bits;
`ifdef SRAMC_ERR_RESP_EN
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ERR2: hresp = HRESP_ERROR;
`endif
      default: ;
    endcase
  end

  assign sram_addr = addr_q;

endmodule
